// File: rtl/match_scheduler_if.sv
// Scheduler bundle: job config, window-memory read port, accelerator handshake,
// result FIFO head and job status. master = scheduler side.
interface match_scheduler_if #(
   parameter int WORDS = 24
);
   logic                 cfg_go;
   logic [15:0]          cfg_base;
   logic [7:0]           cfg_count;
   logic                 mem_rd;
   logic [15:0]          mem_addr;
   logic [63:0]          mem_rdata;
   logic [64*WORDS-1:0]  bmr;
   logic                 acc_start;
   logic                 acc_finish;
   logic [15:0]          acc_note;
   logic [15:0]          acc_length;
   logic                 res_valid;
   logic [15:0]          res_note;
   logic [15:0]          res_length;
   logic                 res_pop;
   logic                 busy;
   logic                 done;
   logic                 err_timeout;

   modport master (
      input  cfg_go, cfg_base, cfg_count, mem_rdata, acc_finish, acc_note, acc_length, res_pop,
      output mem_rd, mem_addr, bmr, acc_start, res_valid, res_note, res_length, busy, done, err_timeout
   );
   modport slave (
      output cfg_go, cfg_base, cfg_count, mem_rdata, acc_finish, acc_note, acc_length, res_pop,
      input  mem_rd, mem_addr, bmr, acc_start, res_valid, res_note, res_length, busy, done, err_timeout
   );
endinterface

// File: rtl/match_scheduler.sv
// Per-symbol job sequencer: gathers a WORDS-beat window from memory, runs the
// match accelerator on it, and queues {note,length} results in a small FIFO.
module match_scheduler #(
   parameter int WORDS      = 24,
   parameter int TIMEOUT    = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   match_scheduler_if.master  bus
);
   localparam int BW = $clog2(WORDS + 2);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, STORE, STALL, DONE} state_t;

   state_t              r_state;
   logic [15:0]         r_base;
   logic [7:0]          r_count;
   logic [7:0]          r_sym;
   logic [BW-1:0]       r_beat;
   logic [TW-1:0]       r_tmo;
   logic                r_mem_rd;
   logic [15:0]         r_mem_addr;
   logic [64*WORDS-1:0] r_bmr;
   logic                r_acc_start;
   logic                r_err;
   logic [15:0]         r_note;
   logic [15:0]         r_len;

   logic [15:0]         r_fifo_note [FIFO_DEPTH];
   logic [15:0]         r_fifo_len  [FIFO_DEPTH];
   logic [PW-1:0]       r_wp;
   logic [PW-1:0]       r_rp;
   logic [CW-1:0]       r_cnt;

   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_last;
   logic                w_go;
   logic [15:0]         w_next_addr;

   assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
   assign w_push      = ((r_state == STORE) || (r_state == STALL)) && !w_full;
   assign w_pop       = bus.res_pop && (r_cnt != '0);
   assign w_last      = ({1'b0, r_sym} + 9'd1) >= {1'b0, r_count};
   assign w_go        = bus.cfg_go && ((r_state == IDLE) || (r_state == DONE));
   assign w_next_addr = r_base + 16'((32'(r_sym) + 32'd1) * 32'(WORDS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_count     <= '0;
         r_sym       <= '0;
         r_beat      <= '0;
         r_tmo       <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_bmr       <= '0;
         r_acc_start <= 1'b0;
         r_err       <= 1'b0;
         r_note      <= '0;
         r_len       <= '0;
      end else begin
         r_acc_start <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_go) begin
                  r_base  <= bus.cfg_base;
                  r_count <= bus.cfg_count;
                  r_sym   <= '0;
                  r_err   <= 1'b0;
                  if (bus.cfg_count != 8'd0) begin
                     r_state    <= FETCH;
                     r_beat     <= '0;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= bus.cfg_base;
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            FETCH: begin
               // r_beat is the beat on the bus now; the previous beat's data is arriving
               if (r_beat != '0)
                  r_bmr[64*(int'(r_beat)-1) +: 64] <= bus.mem_rdata;
               r_mem_rd <= (int'(r_beat) < WORDS - 1);
               if (int'(r_beat) < WORDS - 1)
                  r_mem_addr <= r_mem_addr + 16'd1;
               if (int'(r_beat) == WORDS) begin
                  r_state     <= START;
                  r_acc_start <= 1'b1;
               end
               r_beat <= r_beat + BW'(1);
            end
            START: begin
               r_state <= WAIT;
               r_tmo   <= '0;
            end
            WAIT: begin
               if (bus.acc_finish) begin
                  r_note  <= bus.acc_note;
                  r_len   <= bus.acc_length;
                  r_state <= STORE;
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            STORE, STALL: begin
               if (w_push) begin
                  if (w_last) begin
                     r_state <= DONE;
                  end else begin
                     r_sym      <= r_sym + 8'd1;
                     r_state    <= FETCH;
                     r_beat     <= '0;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= w_next_addr;
                  end
               end else begin
                  r_state <= STALL;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_note[r_wp] <= r_note;
         r_fifo_len[r_wp]  <= r_len;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push)
            r_wp <= (int'(r_wp) == FIFO_DEPTH - 1) ? '0 : r_wp + PW'(1);
         if (w_pop)
            r_rp <= (int'(r_rp) == FIFO_DEPTH - 1) ? '0 : r_rp + PW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   assign bus.mem_rd      = r_mem_rd;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.bmr         = r_bmr;
   assign bus.acc_start   = r_acc_start;
   assign bus.res_valid   = (r_cnt != '0);
   assign bus.res_note    = (r_cnt != '0) ? r_fifo_note[r_rp] : 16'd0;
   assign bus.res_length  = (r_cnt != '0) ? r_fifo_len[r_rp]  : 16'd0;
   assign bus.busy        = (r_state != IDLE) && (r_state != DONE);
   assign bus.done        = (r_state == DONE);
   assign bus.err_timeout = r_err;
endmodule
